// File: rtl/framebuffer_scanout_pkg.sv
// Shared types and default XGA timing for the frame-buffer scan-out path.
package framebuffer_scanout_pkg;

    localparam int unsigned H_ACTIVE     = 1024;
    localparam int unsigned H_FP         = 24;
    localparam int unsigned H_SYNC       = 136;
    localparam int unsigned H_BP         = 160;
    localparam int unsigned V_ACTIVE     = 768;
    localparam int unsigned V_FP         = 3;
    localparam int unsigned V_SYNC       = 6;
    localparam int unsigned V_BP         = 29;
    localparam int unsigned FB_WIDTH     = 512;
    localparam int unsigned ADDR_BITS    = 18;
    localparam int unsigned READ_LATENCY = 2;
    localparam int unsigned DATA_BITS    = 16;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
    } Rgb444;

    // Raster controls that travel alongside the BRAM read.
    typedef struct packed {
        logic vis;
        logic hs;
        logic vs;
        logic first_px;
    } ctrl_t;

    localparam int unsigned CTRL_BITS = $bits(ctrl_t);

endpackage

// File: rtl/framebuffer_scanout_if.sv
// BRAM port-B read bus plus the VGA pin-side outputs of the scan-out block.
interface framebuffer_scanout_if
    import framebuffer_scanout_pkg::*;
#(
    parameter int unsigned ADDR_BITS = framebuffer_scanout_pkg::ADDR_BITS
);
    logic [ADDR_BITS-1:0] fb_addr;
    logic [DATA_BITS-1:0] fb_data;
    logic [3:0]           vga_r;
    logic [3:0]           vga_g;
    logic [3:0]           vga_b;
    logic                 hsync;
    logic                 vsync;
    logic                 blank;

    modport master (
        output fb_addr,
        input  fb_data,
        output vga_r, vga_g, vga_b, hsync, vsync, blank
    );

    modport slave (
        input  fb_addr,
        output fb_data,
        input  vga_r, vga_g, vga_b, hsync, vsync, blank
    );
endinterface

// File: rtl/framebuffer_scanout_delay_line.sv
// Fixed-depth shift register with synchronous clear to all zeros.
module delay_line #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) stage[i] <= '0;
        end else begin
            stage[0] <= d;
            for (int i = 1; i < int'(DEPTH); i++) stage[i] <= stage[i-1];
        end
    end

    assign q = stage[DEPTH-1];
endmodule

// File: rtl/framebuffer_scanout.sv
// Raster timing generator and 2x-upscaling frame-buffer reader on the pixel clock.
// Colour, syncs and blank leave the block aligned after READ_LATENCY+2 cycles.
module framebuffer_scanout
    import framebuffer_scanout_pkg::*;
#(
    parameter int unsigned H_ACTIVE     = framebuffer_scanout_pkg::H_ACTIVE,
    parameter int unsigned H_FP         = framebuffer_scanout_pkg::H_FP,
    parameter int unsigned H_SYNC       = framebuffer_scanout_pkg::H_SYNC,
    parameter int unsigned H_BP         = framebuffer_scanout_pkg::H_BP,
    parameter int unsigned V_ACTIVE     = framebuffer_scanout_pkg::V_ACTIVE,
    parameter int unsigned V_FP         = framebuffer_scanout_pkg::V_FP,
    parameter int unsigned V_SYNC       = framebuffer_scanout_pkg::V_SYNC,
    parameter int unsigned V_BP         = framebuffer_scanout_pkg::V_BP,
    parameter int unsigned FB_WIDTH     = framebuffer_scanout_pkg::FB_WIDTH,
    parameter int unsigned ADDR_BITS    = framebuffer_scanout_pkg::ADDR_BITS,
    parameter int unsigned READ_LATENCY = framebuffer_scanout_pkg::READ_LATENCY
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        display_enable,
    input  logic [11:0]                 bg_color,
    framebuffer_scanout_if.master       bus,
    output logic                        frame_start,
    output logic [15:0]                 frame_count
);
    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HC_W     = $clog2(H_TOTAL);
    localparam int unsigned VC_W     = $clog2(V_TOTAL);
    localparam int unsigned PIPE     = READ_LATENCY + 2;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;

    logic [HC_W-1:0] hc;
    logic [VC_W-1:0] vc;
    logic            h_last;
    logic            v_last;
    logic            en_frame;
    ctrl_t           ctrl_raw;
    ctrl_t           ctrl_dly;
    Rgb444           rgb_next;
    logic [3:0]      unused_fb_hi;

    assign h_last       = (hc == HC_W'(H_TOTAL - 1));
    assign v_last       = (vc == VC_W'(V_TOTAL - 1));
    assign unused_fb_hi = bus.fb_data[15:12];

    // Raster position counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            hc <= '0;
            vc <= '0;
        end else if (h_last) begin
            hc <= '0;
            vc <= v_last ? '0 : vc + VC_W'(1);
        end else begin
            hc <= hc + HC_W'(1);
        end
    end

    always_comb begin
        ctrl_raw          = '0;
        ctrl_raw.vis      = (hc < HC_W'(H_ACTIVE)) && (vc < VC_W'(V_ACTIVE));
        ctrl_raw.hs       = (hc >= HC_W'(HS_START)) && (hc < HC_W'(HS_END));
        ctrl_raw.vs       = (vc >= VC_W'(VS_START)) && (vc < VC_W'(VS_END));
        ctrl_raw.first_px = (hc == '0) && (vc == '0);
    end

    // Each frame-buffer pixel covers a 2x2 block of screen pixels.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.fb_addr <= '0;
        end else if (ctrl_raw.vis) begin
            bus.fb_addr <= ADDR_BITS'(FB_WIDTH) * ADDR_BITS'(vc >> 1) + ADDR_BITS'(hc >> 1);
        end else begin
            bus.fb_addr <= '0;
        end
    end

    // Controls wait out the address register and BRAM latency; the output register adds the last stage.
    delay_line #(
        .WIDTH (CTRL_BITS),
        .DEPTH (PIPE - 1)
    ) u_delay_line (
        .clk (clk),
        .rst (rst),
        .d   (ctrl_raw),
        .q   (ctrl_dly)
    );

    // Enable only changes between frames so a frame is never split.
    always_ff @(posedge clk) begin
        if (rst) begin
            en_frame <= 1'b0;
        end else if (h_last && v_last) begin
            en_frame <= display_enable;
        end
    end

    always_comb begin
        rgb_next = '0;
        if (!ctrl_dly.vis) begin
            rgb_next = '0;
        end else if (en_frame) begin
            rgb_next = Rgb444'(bus.fb_data[11:0]);
        end else begin
            rgb_next = Rgb444'(bg_color);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.vga_r   <= '0;
            bus.vga_g   <= '0;
            bus.vga_b   <= '0;
            bus.hsync   <= 1'b0;
            bus.vsync   <= 1'b0;
            bus.blank   <= 1'b1;
            frame_start <= 1'b0;
            frame_count <= '0;
        end else begin
            bus.vga_r   <= rgb_next.r;
            bus.vga_g   <= rgb_next.g;
            bus.vga_b   <= rgb_next.b;
            bus.hsync   <= ctrl_dly.hs;
            bus.vsync   <= ctrl_dly.vs;
            bus.blank   <= !ctrl_dly.vis;
            frame_start <= ctrl_dly.first_px;
            if (frame_start) begin
                frame_count <= frame_count + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_framebuffer_scanout.sv
// Bench for framebuffer_scanout on a shrunken raster, checked every cycle against a position-based model.
module tb_framebuffer_scanout;
    localparam int HA = 16, HF = 2, HS = 3, HB = 4;
    localparam int VA = 12, VF = 1, VS = 2, VB = 2;
    localparam int FBW = 8, LAT = 2, PIPE = LAT + 2;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic        clk = 1'b0;
    logic        rst;
    logic        display_enable;
    logic [11:0] bg_color;
    logic        frame_start;
    logic [15:0] frame_count;
    logic [17:0] rd_pipe;

    int tests = 0;
    int fails = 0;
    int t     = 0;
    bit en_of_frame [64];
    int hs_cnt, vs_cnt, vis_cnt;
    bit stats_valid;

    framebuffer_scanout_if #(.ADDR_BITS(18)) bus ();

    framebuffer_scanout #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .FB_WIDTH(FBW), .ADDR_BITS(18), .READ_LATENCY(LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .display_enable (display_enable),
        .bg_color       (bg_color),
        .bus            (bus),
        .frame_start    (frame_start),
        .frame_count    (frame_count)
    );

    always #5 clk = ~clk;

    // BRAM whose content is its own address; the top nibble is junk the DUT must ignore.
    always @(posedge clk) begin
        rd_pipe     <= bus.fb_addr;
        bus.fb_data <= {4'($urandom), rd_pipe[11:0]};
    end

    function automatic int pix_addr(input int h, input int v);
        return FBW * (v / 2) + h / 2;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got 0x%0h expected 0x%0h at t=%0d", tag, got, exp, t);
        end
    endtask

    // Expected outputs follow from how many cycles have elapsed since counters sat at (0,0).
    task automatic check_cycle();
        int p, f, q, h, v, fc;
        logic        e_blank, e_hs, e_vs, e_fs;
        logic [11:0] e_rgb;
        logic [17:0] e_addr;

        e_addr = '0;
        if (t > 0) begin
            q = (t - 1) % FRAME;
            h = q % HT;
            v = q / HT;
            if (h < HA && v < VA) e_addr = 18'(pix_addr(h, v));
        end

        e_blank = 1'b1; e_hs = 1'b0; e_vs = 1'b0; e_fs = 1'b0; e_rgb = '0;
        q = -1;
        if (t >= PIPE) begin
            p = t - PIPE;
            f = p / FRAME;
            q = p % FRAME;
            h = q % HT;
            v = q / HT;
            e_blank = !(h < HA && v < VA);
            e_hs    = (h >= HA + HF) && (h < HA + HF + HS);
            e_vs    = (v >= VA + VF) && (v < VA + VF + VS);
            e_fs    = (q == 0);
            if (!e_blank) e_rgb = en_of_frame[f % 64] ? 12'(pix_addr(h, v)) : bg_color;
        end
        fc = (t > PIPE) ? ((t - PIPE - 1) / FRAME + 1) : 0;

        check("fb_addr", 32'(bus.fb_addr), 32'(e_addr));
        check("blank", 32'(bus.blank), 32'(e_blank));
        check("hsync", 32'(bus.hsync), 32'(e_hs));
        check("vsync", 32'(bus.vsync), 32'(e_vs));
        check("rgb", 32'({bus.vga_r, bus.vga_g, bus.vga_b}), 32'(e_rgb));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("frame_count", 32'(frame_count), 32'(fc % 65536));

        if (q == 0) begin
            stats_valid = 1'b1;
            hs_cnt = 0; vs_cnt = 0; vis_cnt = 0;
        end
        if (stats_valid) begin
            hs_cnt  += int'(bus.hsync);
            vs_cnt  += int'(bus.vsync);
            vis_cnt += int'(!bus.blank);
            if (q == FRAME - 1) begin
                check("hsync_per_frame", 32'(hs_cnt), 32'(HS * VT));
                check("vsync_per_frame", 32'(vs_cnt), 32'(VS * HT));
                check("visible_per_frame", 32'(vis_cnt), 32'(HA * VA));
            end
        end
    endtask

    // The enable held at the edge closing a counter frame governs the next frame.
    task automatic tick();
        if (t % FRAME == FRAME - 1) en_of_frame[(t / FRAME + 1) % 64] = display_enable;
        @(posedge clk);
        t++;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic do_reset(input logic [11:0] new_bg);
        rst      = 1'b1;
        bg_color = new_bg;
        @(posedge clk);
        #1 rst = 1'b0;
        t = 0;
        foreach (en_of_frame[i]) en_of_frame[i] = 1'b0;
        stats_valid = 1'b0;
        @(negedge clk);
        check_cycle();
    endtask

    initial begin
        rst            = 1'b1;
        display_enable = 1'b1;
        bg_color       = 12'($urandom);
        stats_valid    = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_reset(12'($urandom));

        // First frame after reset shows background, later frames show BRAM data.
        repeat (3 * FRAME) tick();

        // Disable mid-frame: current frame keeps BRAM data, the next shows background.
        while (t % FRAME != 6 * HT + 10) tick();
        display_enable = 1'b0;
        repeat (2 * FRAME) tick();

        // Random enable toggles at random raster positions.
        for (int k = 0; k < 6; k++) begin
            repeat ($urandom_range(1, FRAME)) tick();
            display_enable = 1'($urandom_range(0, 1));
        end

        // Reset in the middle of a frame.
        while (t % FRAME != 7 * HT + 10) tick();
        display_enable = 1'b1;
        do_reset(12'hF0F);
        repeat (3 * FRAME + 10) tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
